// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Parametrised APB3 master. It converts a simple request port
//               (transfer / READ_WRITE / address / data) into SETUP and ACCESS
//               bus cycles towards NUM_SLV slaves. The slave is decoded from
//               the top address bits. The selected slave's PREADY, PRDATA and
//               PSLVERR are muxed back to the requester. Back-to-back
//               transfers and slave wait states are supported.
// Optional    : define APB_TIMEOUT_EN to abort ACCESS phases that last
//               TIMEOUT cycles without PREADY. The transfer then completes
//               with PSLVERR=1.
// Ports       : PCLK, PRESETn (async, active low)
//               request : transfer, READ_WRITE, apb_write_paddr,
//                         apb_write_data, apb_read_paddr
//               bus     : PSEL[NUM_SLV], PENABLE, PWRITE, PADDR, PWDATA,
//                         PREADY_s, PRDATA_s (slave i at [i*DATA_W +: DATA_W]),
//                         PSLVERR_s
//               status  : apb_read_data_out, PSLVERR, xfer_done, busy
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      transfer,
    input  logic                      READ_WRITE,
    input  logic [ADDR_W-1:0]         apb_write_paddr,
    input  logic [DATA_W-1:0]         apb_write_data,
    input  logic [ADDR_W-1:0]         apb_read_paddr,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV-1:0]        PREADY_s,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA_s,
    input  logic [NUM_SLV-1:0]        PSLVERR_s,
    output logic [DATA_W-1:0]         apb_read_data_out,
    output logic                      PSLVERR,
    output logic                      xfer_done,
    output logic                      busy
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 0;
    localparam int IDX_W = (SEL_W > 0) ? SEL_W : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------
    // Request side: pick the address for the requested direction and decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_req_addr;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_req_ok;
    logic [NUM_SLV-1:0] w_req_psel;

    assign w_req_addr = READ_WRITE ? apb_write_paddr : apb_read_paddr;

    generate
        if (SEL_W > 0) begin : g_sel_decode
            assign w_req_idx = w_req_addr[ADDR_W-1 -: SEL_W];
            // If NUM_SLV is not a power of two, the upper index codes map to no slave.
            assign w_req_ok  = (32'(w_req_idx) < 32'(NUM_SLV));
        end else begin : g_sel_single
            assign w_req_idx = '0;
            assign w_req_ok  = 1'b1;
        end
    endgenerate

    assign w_req_psel = w_req_ok ? (NUM_SLV'(1) << w_req_idx) : '0;

    // ------------------------------------------------------------------
    // Response side: PSEL is one-hot (or zero on a decode error), so it
    // steers the mux directly. Non-selected slaves contribute nothing.
    // ------------------------------------------------------------------
    logic              w_sel_ready;
    logic              w_sel_err;
    logic [DATA_W-1:0] w_sel_rdata;

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (PSEL[i]) begin
                w_sel_ready = PREADY_s[i];
                w_sel_err   = PSLVERR_s[i];
                w_sel_rdata = PRDATA_s[i*DATA_W +: DATA_W];
            end
        end
    end

    logic w_in_access;
    logic w_dec_err;
    logic w_tmo;
    logic w_fault;
    logic w_done;
    logic w_accept;

    assign w_in_access = (r_state == ST_ACCESS);
    // No PSEL bit in a running transfer means that the address decoded to no slave.
    assign w_dec_err   = ~|PSEL;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_tcnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tcnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tcnt <= '0;
        end else if (w_in_access && !w_sel_ready) begin
            r_tcnt <= r_tcnt + CNT_W'(1);
        end
    end

    // This cycle is the TIMEOUT-th cycle without PREADY. A PREADY that
    // arrives on the same edge wins.
    assign w_tmo = w_in_access && !w_sel_ready && (r_tcnt == CNT_W'(TIMEOUT - 1));
`else
    // Without the timeout an ACCESS phase waits for PREADY with no limit. TIMEOUT has no effect.
    assign w_tmo = (TIMEOUT < 0);
`endif

    assign w_fault  = w_dec_err | w_tmo;
    assign w_done   = w_in_access & (w_sel_ready | w_fault);
    // A new request is taken in IDLE, or on the edge that completes the current transfer.
    assign w_accept = transfer & ((r_state == ST_IDLE) | w_done);

    // ------------------------------------------------------------------
    // Main FSM with registered bus and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state           <= ST_IDLE;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b0;
            PADDR             <= '0;
            PWDATA            <= '0;
            apb_read_data_out <= '0;
            PSLVERR           <= 1'b0;
            xfer_done         <= 1'b0;
            busy              <= 1'b0;
        end else begin
            xfer_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        xfer_done <= 1'b1;
                        PSLVERR   <= w_sel_ready ? w_sel_err : 1'b1;
                        if (!PWRITE) begin
                            apb_read_data_out <= w_sel_ready ? w_sel_rdata : '0;
                        end
                        PENABLE <= 1'b0;
                        PSEL    <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            // A new request is written last. It replaces the IDLE return
            // that the completion code above scheduled.
            if (w_accept) begin
                PSEL    <= w_req_psel;
                PENABLE <= 1'b0;
                PWRITE  <= READ_WRITE;
                PADDR   <= w_req_addr;
                if (READ_WRITE) begin
                    PWDATA <= apb_write_data;
                end
                busy    <= 1'b1;
                r_state <= ST_SETUP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge. It uses a table
//               of directed transfers and hand-written sequences for
//               back-to-back transfers, decode error, reset in mid-transfer
//               and ACCESS timeout / indefinite wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;

    // Main DUT: ADDR_W=9, DATA_W=8, NUM_SLV=2, TIMEOUT=4
    logic        transfer, READ_WRITE;
    logic [8:0]  apb_write_paddr, apb_read_paddr;
    logic [7:0]  apb_write_data;
    logic [1:0]  PSEL;
    logic        PENABLE, PWRITE;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [1:0]  PREADY_s, PSLVERR_s;
    logic [15:0] PRDATA_s;
    logic [7:0]  apb_read_data_out;
    logic        PSLVERR, xfer_done, busy;

    // Second DUT: NUM_SLV=3, used for the decode-error case
    logic        transfer2, READ_WRITE2;
    logic [8:0]  apb_write_paddr2, apb_read_paddr2;
    logic [7:0]  apb_write_data2;
    logic [2:0]  PSEL2;
    logic        PENABLE2, PWRITE2;
    logic [8:0]  PADDR2;
    logic [7:0]  PWDATA2;
    logic [2:0]  PREADY_s2, PSLVERR_s2;
    logic [23:0] PRDATA_s2;
    logic [7:0]  apb_read_data_out2;
    logic        PSLVERR2, xfer_done2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY_s(PREADY_s), .PRDATA_s(PRDATA_s), .PSLVERR_s(PSLVERR_s),
        .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR),
        .xfer_done(xfer_done), .busy(busy)
    );

    apb_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(16)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .transfer(transfer2), .READ_WRITE(READ_WRITE2),
        .apb_write_paddr(apb_write_paddr2), .apb_write_data(apb_write_data2),
        .apb_read_paddr(apb_read_paddr2),
        .PSEL(PSEL2), .PENABLE(PENABLE2), .PWRITE(PWRITE2), .PADDR(PADDR2), .PWDATA(PWDATA2),
        .PREADY_s(PREADY_s2), .PRDATA_s(PRDATA_s2), .PSLVERR_s(PSLVERR_s2),
        .apb_read_data_out(apb_read_data_out2), .PSLVERR(PSLVERR2),
        .xfer_done(xfer_done2), .busy(busy2)
    );

    typedef struct {
        logic       rw;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] srdata;     // data returned by the target slave
        int         slv;
        int         waits;
        logic       serr;       // PSLVERR from the target slave
        logic [1:0] exp_psel;
        logic [7:0] exp_rdata;  // apb_read_data_out after completion
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge PCLK);
        transfer        = 1'b1;
        READ_WRITE      = v.rw;
        apb_write_paddr = v.rw ? v.addr : ~v.addr;
        apb_read_paddr  = v.rw ? ~v.addr : v.addr;
        apb_write_data  = v.wdata;
        PREADY_s        = 2'b11;   // the master must ignore ready during SETUP
        PRDATA_s        = (v.slv == 0) ? {~v.srdata, v.srdata} : {v.srdata, ~v.srdata};
        PSLVERR_s       = (v.slv == 0) ? {~v.serr, v.serr} : {v.serr, ~v.serr};
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        chk("setup_psel", 32'(PSEL), 32'(v.exp_psel));
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", 32'(PADDR), 32'(v.addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(v.rw));
        chk("setup_busy", 32'(busy), 32'd1);
        if (v.rw) chk("setup_pwdata", 32'(PWDATA), 32'(v.wdata));
        PREADY_s = (v.slv == 0) ? 2'b10 : 2'b01;   // only the non-selected slave is ready
        @(posedge PCLK);
        for (int i = 0; i <= v.waits; i++) begin
            @(negedge PCLK);
            chk("access_penable", 32'(PENABLE), 32'd1);
            chk("access_psel", 32'(PSEL), 32'(v.exp_psel));
            chk("access_paddr", 32'(PADDR), 32'(v.addr));
            chk("access_no_done", 32'(xfer_done), 32'd0);
            if (i == v.waits) PREADY_s = 2'b11;
            @(posedge PCLK);
        end
        @(negedge PCLK);
        PREADY_s = 2'b00;
        chk("done_pulse", 32'(xfer_done), 32'd1);
        chk("done_pslverr", 32'(PSLVERR), 32'(v.exp_err));
        chk("done_rdata", 32'(apb_read_data_out), 32'(v.exp_rdata));
        chk("done_psel", 32'(PSEL), 32'd0);
        chk("done_penable", 32'(PENABLE), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        @(negedge PCLK);
        chk("done_low", 32'(xfer_done), 32'd0);
        chk("hold_rdata", 32'(apb_read_data_out), 32'(v.exp_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{1'b1, 9'h055, 8'hA5, 8'hEE, 0, 0, 1'b0, 2'b01, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 9'h1F0, 8'h00, 8'h3C, 1, 3, 1'b0, 2'b10, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 9'h1AA, 8'h96, 8'h11, 1, 1, 1'b1, 2'b10, 8'h3C, 1'b1};
        vecs[3] = '{1'b0, 9'h00F, 8'h00, 8'hC3, 0, 0, 1'b0, 2'b01, 8'hC3, 1'b0};
        vecs[4] = '{1'b0, 9'h100, 8'h00, 8'h81, 1, 2, 1'b1, 2'b10, 8'h81, 1'b1};
        vecs[5] = '{1'b1, 9'h0FF, 8'h00, 8'h42, 0, 0, 1'b0, 2'b01, 8'h81, 1'b0};

        PRESETn = 1'b0;
        transfer = 1'b0; READ_WRITE = 1'b0;
        apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
        PREADY_s = '0; PRDATA_s = '0; PSLVERR_s = '0;
        transfer2 = 1'b0; READ_WRITE2 = 1'b0;
        apb_write_paddr2 = '0; apb_read_paddr2 = '0; apb_write_data2 = '0;
        PREADY_s2 = '0; PRDATA_s2 = '0; PSLVERR_s2 = '0;

        // Reset state
        #1;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(xfer_done), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_rdata", 32'(apb_read_data_out), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        // Directed single transfers
        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Back-to-back: write 0x010 (slave0), then read 0x110 (slave1) with transfer held high
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = 1'b1;
        apb_write_paddr = 9'h010; apb_write_data = 8'h5A; apb_read_paddr = 9'h110;
        PREADY_s = 2'b11; PSLVERR_s = 2'b00; PRDATA_s = {8'h77, 8'h00};
        @(posedge PCLK);
        @(negedge PCLK);
        chk("b2b_setup1_psel", 32'(PSEL), 32'h1);
        READ_WRITE = 1'b0;   // next request is a read; it is ignored in SETUP
        @(posedge PCLK);
        @(negedge PCLK);
        chk("b2b_access1_penable", 32'(PENABLE), 32'd1);
        chk("b2b_access1_paddr", 32'(PADDR), 32'h010);
        chk("b2b_access1_pwrite", 32'(PWRITE), 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        chk("b2b_done1", 32'(xfer_done), 32'd1);
        chk("b2b_setup2_psel", 32'(PSEL), 32'h2);
        chk("b2b_setup2_penable", 32'(PENABLE), 32'd0);
        chk("b2b_setup2_paddr", 32'(PADDR), 32'h110);
        chk("b2b_setup2_pwrite", 32'(PWRITE), 32'd0);
        chk("b2b_setup2_busy", 32'(busy), 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("b2b_access2_penable", 32'(PENABLE), 32'd1);
        chk("b2b_access2_nodone", 32'(xfer_done), 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("b2b_done2", 32'(xfer_done), 32'd1);
        chk("b2b_rdata", 32'(apb_read_data_out), 32'h77);
        chk("b2b_idle_psel", 32'(PSEL), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        PREADY_s = 2'b00;

        // Decode error on the 3-slave instance: read 0x1C0 gives index 3
        @(negedge PCLK);
        transfer2 = 1'b1; READ_WRITE2 = 1'b0;
        apb_read_paddr2 = 9'h1C0; apb_write_paddr2 = 9'h000;
        PREADY_s2 = 3'b000; PRDATA_s2 = 24'hABCDEF; PSLVERR_s2 = 3'b000;
        @(posedge PCLK);
        @(negedge PCLK);
        transfer2 = 1'b0;
        chk("dec_setup_psel", 32'(PSEL2), 32'd0);
        chk("dec_setup_busy", 32'(busy2), 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("dec_access_penable", 32'(PENABLE2), 32'd1);
        chk("dec_access_psel", 32'(PSEL2), 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("dec_done", 32'(xfer_done2), 32'd1);
        chk("dec_pslverr", 32'(PSLVERR2), 32'd1);
        chk("dec_rdata", 32'(apb_read_data_out2), 32'd0);
        chk("dec_busy", 32'(busy2), 32'd0);

        // Reset during ACCESS with PREADY low
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = 1'b1;
        apb_write_paddr = 9'h033; apb_write_data = 8'h77; PREADY_s = 2'b00;
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_mid_access", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_paddr", 32'(PADDR), 32'd0);
        chk("rst_mid_pwdata", 32'(PWDATA), 32'd0);
        chk("rst_mid_rdata", 32'(apb_read_data_out), 32'd0);
        @(negedge PCLK);
        chk("rst_mid_nodone", 32'(xfer_done), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        run_vec('{1'b1, 9'h044, 8'h5C, 8'h21, 0, 1, 1'b0, 2'b01, 8'h00, 1'b0});

        // Slave 1 never becomes ready
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = 1'b0;
        apb_read_paddr = 9'h1C4; apb_write_paddr = 9'h000;
        PREADY_s = 2'b00; PRDATA_s = {8'h99, 8'h66}; PSLVERR_s = 2'b00;
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        @(posedge PCLK);
`ifdef APB_TIMEOUT_EN
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1 || xfer_done !== 1'b0) bad++;
            @(posedge PCLK);
        end
        chk("tmo_access_cycles", 32'(bad), 32'd0);
        @(negedge PCLK);
        chk("tmo_done", 32'(xfer_done), 32'd1);
        chk("tmo_pslverr", 32'(PSLVERR), 32'd1);
        chk("tmo_rdata", 32'(apb_read_data_out), 32'd0);
        chk("tmo_psel", 32'(PSEL), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
`else
        bad = 0;
        repeat (100) begin
            @(negedge PCLK);
            if (busy !== 1'b1 || PENABLE !== 1'b1 || xfer_done !== 1'b0) bad++;
        end
        chk("wait_forever_cycles", 32'(bad), 32'd0);
        chk("wait_forever_psel", 32'(PSEL), 32'h2);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        chk("wait_forever_rst_busy", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
